// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the upstream issue handshake, the ALU operand/result bus and the result handshake.
// The master modport is the controller's view, and the slave modport is the surrounding datapath's view.
interface alu_issue_ctrl_if #(
  parameter int W    = 32,
  parameter int OP_W = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [W-1:0]    in_rs;
  logic [W-1:0]    in_rt;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [OP_W-1:0] alu_op;
  logic [W-1:0]    alu_z;
  logic            alu_zero;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_z;
  logic            out_zero;
  logic            out_taken;
  logic            out_err;
  logic            chk_err;

  modport master (
    input  in_valid, in_instr, in_rs, in_rt, alu_z, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_z, out_zero,
           out_taken, out_err, chk_err
  );

  modport slave (
    output in_valid, in_instr, in_rs, in_rt, alu_z, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_z, out_zero,
           out_taken, out_err, chk_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller. It decodes a MIPS instruction, drives the combinational ALU, and returns the captured result.
// Define ALU_CHECK_EN to add a reference model that compares against the ALU and reports mismatches on chk_err.
module alu_issue_ctrl #(
  parameter int W    = 32,
  parameter int OP_W = 3
) (
  input logic              clk,
  input logic              rst,
  alu_issue_ctrl_if.master bus
);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(3'b000);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3'b001);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(3'b010);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3'b110);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(3'b111);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [5:0]      opc_q;
  logic [15:0]     imm_q;
  logic [W-1:0]    rs_q, rt_q;
  logic [W-1:0]    alu_a_q, alu_b_q;
  logic [OP_W-1:0] alu_op_q;
  logic [W-1:0]    out_z_q;
  logic            out_zero_q, out_taken_q, out_err_q;
  logic [OP_W-1:0] dec_op;
  logic            dec_imm, dec_illegal, dec_beq;
  logic [W-1:0]    imm_ext;
  logic            accept;
  logic            unused_instr;

  // Register-number fields are consumed by the register-read stage, not here.
  assign unused_instr = ^bus.in_instr[25:16];
  assign accept       = (state_q == S_IDLE) && bus.in_valid;
  assign imm_ext      = {{(W-16){imm_q[15]}}, imm_q};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.in_valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_DONE;
      S_DONE:   if (bus.out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
  end

  // Funct field shares its bits with the low immediate bits.
  always_comb begin
    dec_op      = OP_ADD;
    dec_imm     = 1'b0;
    dec_illegal = 1'b0;
    dec_beq     = 1'b0;
    case (opc_q)
      6'h00: begin
        case (imm_q[5:0])
          6'h20:   dec_op = OP_ADD;
          6'h22:   dec_op = OP_SUB;
          6'h24:   dec_op = OP_AND;
          6'h25:   dec_op = OP_OR;
          6'h2A:   dec_op = OP_SLT;
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h08, 6'h23, 6'h2B: dec_imm = 1'b1;
      6'h04: begin
        dec_op  = OP_SUB;
        dec_beq = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // NOTE: datapath registers are reset too, because every output must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      opc_q       <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      out_z_q     <= '0;
      out_zero_q  <= 1'b0;
      out_taken_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        opc_q <= bus.in_instr[31:26];
        imm_q <= bus.in_instr[15:0];
        rs_q  <= bus.in_rs;
        rt_q  <= bus.in_rt;
      end
      if (state_q == S_DECODE) begin
        alu_a_q  <= rs_q;
        alu_b_q  <= dec_imm ? imm_ext : rt_q;
        alu_op_q <= dec_op;
      end
      if (state_q == S_EXEC) begin
        out_z_q     <= bus.alu_z;
        out_zero_q  <= bus.alu_zero;
        out_taken_q <= dec_beq & bus.alu_zero;
        out_err_q   <= dec_illegal;
      end
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.out_z     = out_z_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_taken = out_taken_q;
  assign bus.out_err   = out_err_q;

`ifdef ALU_CHECK_EN
  logic [W-1:0] ref_z;
  logic         chk_err_q;

  always_comb begin
    ref_z = alu_a_q + alu_b_q;
    case (alu_op_q)
      OP_AND:  ref_z = alu_a_q & alu_b_q;
      OP_OR:   ref_z = alu_a_q | alu_b_q;
      OP_SUB:  ref_z = alu_a_q - alu_b_q;
      OP_SLT:  ref_z = {{(W-1){1'b0}}, ($signed(alu_a_q) < $signed(alu_b_q))};
      default: ref_z = alu_a_q + alu_b_q;
    endcase
  end

  // The flag is cleared when the next transaction is accepted and held through DONE.
  always_ff @(posedge clk) begin
    if (rst)                   chk_err_q <= 1'b0;
    else if (accept)           chk_err_q <= 1'b0;
    else if (state_q == S_EXEC)
      chk_err_q <= (ref_z != bus.alu_z) || (bus.alu_zero != (bus.alu_z == '0));
  end

  assign bus.chk_err = chk_err_q;
`else
  assign bus.chk_err = 1'b0;
`endif
endmodule
